// File: rtl/bin2bcd_converter.sv
// Iterative double-dabble converter: binary value in, packed BCD out after BIN_W shift cycles.
// Results above MAX_VAL saturate to all nines and raise ovf_o; the result is held between conversions.
module bin2bcd_converter #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);

    localparam int                BCD_W    = 4 * DIGITS;
    localparam int                CNT_W    = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [BIN_W-1:0]  bin_sr;
    logic [BCD_W-1:0]  scratch;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_q;
    logic [BCD_W-1:0]  scratch_adj;
    logic [BCD_W-1:0]  scratch_next;

    // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5)
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] s, input logic ovf);
        return ovf ? {DIGITS{4'h9}} : s;
    endfunction

    assign scratch_adj  = dabble(scratch);
    assign scratch_next = {scratch_adj[BCD_W-2:0], bin_sr[BIN_W-1]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            bcd_o   <= '0;
            ovf_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        bin_sr  <= bin_i;
                        scratch <= '0;
                        cnt     <= CNT_LOAD;
                        ovf_q   <= (bin_i > MAX_BIN);
                        busy_o  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    bin_sr  <= bin_sr << 1;
                    cnt     <= cnt - CNT_LAST;
                    // The final shift result is published on the same edge that enters DONE.
                    if (cnt == CNT_LAST) begin
                        bcd_o  <= saturate(scratch_next, ovf_q);
                        ovf_o  <= ovf_q;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: cycle-level behavioural model plus literal spot checks.
// Conversion accepted at edge 0 keeps busy_o high for 15 cycles, done_o in the last of them.
module tb_bin2bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd;

    int checks = 0;
    int failures = 0;

    bin2bcd_converter #(.BIN_W(14), .DIGITS(4), .MAX_VAL(9999)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .bin_i(bin),
        .busy_o(busy), .done_o(done), .bcd_o(bcd), .ovf_o(ovf)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int m;
        m = (v > 9999) ? 9999 : v;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Behavioural model: remaining busy cycles after an accepted start, result from arithmetic.
    int          busy_left = 0;
    int          pend_v = 0;
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_bcd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left = 0;
            m_done    = 1'b0;
            m_ovf     = 1'b0;
            m_bcd     = '0;
        end else begin
            m_done = 1'b0;
            if (busy_left == 0) begin
                if (start) begin
                    busy_left = 15;
                    pend_v    = int'(bin);
                end
            end else begin
                busy_left--;
                if (busy_left == 1) begin
                    m_done = 1'b1;
                    m_bcd  = to_bcd(pend_v);
                    m_ovf  = (pend_v > 9999);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(busy_left != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("bcd",  32'(bcd),  32'(m_bcd));
        chk("ovf",  32'(ovf),  32'(m_ovf));
    end

    task automatic do_start(input int v);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run_conv(input string name, input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        do_start(v);
        wait_done(name);
        chk({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        chk({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int v;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_bcd",  32'(bcd),  32'h0);
        chk("rst_ovf",  32'(ovf),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero input and busy/done duration
        run_conv("zero", 0, 16'h0000, 1'b0);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        chk("lat_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("lat_done_pulses", 32'(done_cnt), 32'd1);
        chk("v1234_bcd", 32'(bcd), 32'h1234);

        // Saturation boundaries
        run_conv("v9999",  9999,  16'h9999, 1'b0);
        run_conv("v10000", 10000, 16'h9999, 1'b1);
        run_conv("v16383", 16383, 16'h9999, 1'b1);
        run_conv("v4321",  4321,  16'h4321, 1'b0);

        // Start while busy is ignored
        do_start(57);
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 14'd8888;
        @(negedge clk);
        start = 1'b0;
        wait_done("v57");
        chk("v57_bcd", 32'(bcd), 32'h0057);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("ignored_start_done", 32'(done_cnt), 32'd0);

        // Start held high with bin_i changing every cycle
        start = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            bin = 14'($urandom_range(0, 16383));
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        start = 1'b0;
        chk("held_start_pulses", 32'(done_cnt), 32'd6);
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-conversion
        do_start(4095);
        repeat (6) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_bcd",  32'(bcd),  32'h0);
        chk("abort_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run_conv("v4095", 4095, 16'h4095, 1'b0);

        // Random vectors, weighted towards the saturation boundary
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       v = $urandom_range(9990, 10010);
                1:       v = $urandom_range(0, 20);
                default: v = $urandom_range(0, 16383);
            endcase
            run_conv("rand", v, to_bcd(v), v > 9999);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
